// File: rtl/dot_product_pkg.sv
// Shared types and width helpers for the complex dot-product sequencer.
package dot_product_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int PROD_W(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int ACC_W(input int width, input int addr_w);
        return 2 * width + 1 + addr_w;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register that tracks the multiplier latency.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/dot_product_sequencer.sv
// Sequences RAM reads into the complex multiplier and accumulates the products.
// state | meaning
// IDLE  | waiting for start; results of the last run held
// ISSUE | one RAM read per cycle, addresses 0..len-1
// DRAIN | waiting for the last product to be accumulated
// DONE  | one-cycle done pulse, sums valid
module dot_product_sequencer
    import dot_product_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 4,
    parameter int MULT_LAT = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [ADDR_W-1:0]                         len,
    output logic                                      ram_rd_en,
    output logic [ADDR_W-1:0]                         ram_addr,
    output logic                                      mult_en,
    input  logic signed [PROD_W(WIDTH)-1:0]           prod_real,
    input  logic signed [PROD_W(WIDTH)-1:0]           prod_imag,
    output logic signed [ACC_W(WIDTH, ADDR_W)-1:0]    acc_real,
    output logic signed [ACC_W(WIDTH, ADDR_W)-1:0]    acc_imag,
    output logic                                      busy,
    output logic                                      done
);

    localparam int AW = ACC_W(WIDTH, ADDR_W);

    state_t            state;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] rcv_cnt;
    logic [ADDR_W:0]   issue_next;
    logic [ADDR_W:0]   rcv_next;
    logic              acc_en;

    // ram_addr doubles as the issue counter
    assign issue_next = {1'b0, ram_addr} + (ADDR_W+1)'(1);
    assign rcv_next   = {1'b0, rcv_cnt} + (ADDR_W+1)'(1);

    valid_delay_line #(
        .DEPTH(MULT_LAT)
    ) u_valid_delay_line (
        .clk(clk),
        .rst(rst),
        .d  (mult_en),
        .q  (acc_en)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            rcv_cnt   <= '0;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
            mult_en   <= 1'b0;
            acc_real  <= '0;
            acc_imag  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mult_en <= ram_rd_en;
            done    <= 1'b0;

            if (acc_en) begin
                acc_real <= acc_real + AW'(prod_real);
                acc_imag <= acc_imag + AW'(prod_imag);
                rcv_cnt  <= rcv_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        acc_real <= '0;
                        acc_imag <= '0;
                        rcv_cnt  <= '0;
                        busy     <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            len_q     <= len;
                            ram_rd_en <= 1'b1;
                            ram_addr  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_next < {1'b0, len_q}) begin
                        ram_addr <= issue_next[ADDR_W-1:0];
                    end else begin
                        ram_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // the product landing on this edge is the last one
                    if (acc_en && rcv_next == {1'b0, len_q}) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a cycle-indexed timing model.
module tb_dot_product_sequencer;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
    localparam int LAT    = 2;
    localparam int PW     = 2 * WIDTH + 1;
    localparam int AW     = 2 * WIDTH + 1 + ADDR_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADDR_W-1:0]    len;
    logic                 ram_rd_en;
    logic [ADDR_W-1:0]    ram_addr;
    logic                 mult_en;
    logic signed [PW-1:0] prod_real;
    logic signed [PW-1:0] prod_imag;
    logic signed [AW-1:0] acc_real;
    logic signed [AW-1:0] acc_imag;
    logic                 busy;
    logic                 done;

    dot_product_sequencer #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MULT_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .mult_en(mult_en),
        .prod_real(prod_real), .prod_imag(prod_imag),
        .acc_real(acc_real), .acc_imag(acc_imag),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // stimulus-owned run description
    longint pr_r[2][16];
    longint pr_i[2][16];
    int     m_len;
    bit     m_hold;
    bit     lit_en;
    longint lit_r, lit_i;
    int     lit_done;
    int     run_id;

    // compare-process-owned state
    int     seen_id = 0;
    bit     tracking = 0;
    bit     chained = 0;
    int     ri = 0;
    int     cyc = 0;
    int     done_seen = -1;
    int     n_pass = 0;
    int     n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint exp_sum(input bit imag, input int c);
        longint s = 0;
        for (int k = 0; k < m_len; k++) begin
            if (k + 2 + LAT <= c) s += imag ? pr_i[ri][k] : pr_r[ri][k];
        end
        return s;
    endfunction

    // element k enters at cycle k, result is visible from cycle k+2+LAT
    always @(negedge clk) begin
        int dc;
        int k;
        if (!rst) begin
            check("rst_ram_rd_en", ram_rd_en, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_mult_en", mult_en, 0);
            check("rst_acc_real", acc_real, 0);
            check("rst_acc_imag", acc_imag, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            tracking = 0;
            prod_real = -17'sd12345;
            prod_imag = 17'sd4321;
        end else begin
            if (run_id != seen_id) begin
                seen_id   = run_id;
                tracking  = 1;
                cyc       = 0;
                ri        = 0;
                chained   = 0;
                done_seen = -1;
            end else if (tracking) begin
                cyc++;
            end
            dc = (m_len == 0) ? 0 : m_len + 1 + LAT;
            if (tracking) begin
                check("busy", busy, cyc <= dc);
                check("done", done, cyc == dc);
                if (done && done_seen < 0) done_seen = cyc;
                check("ram_rd_en", ram_rd_en, cyc < m_len);
                if (cyc < m_len) check("ram_addr", ram_addr, cyc);
                check("mult_en", mult_en, (cyc >= 1) && (cyc <= m_len));
                check("acc_real", acc_real, exp_sum(1'b0, cyc));
                check("acc_imag", acc_imag, exp_sum(1'b1, cyc));
            end else begin
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_ram_rd_en", ram_rd_en, 0);
            end
            k = cyc - 1 - LAT;
            if (tracking && k >= 0 && k < m_len) begin
                prod_real = PW'(pr_r[ri][k]);
                prod_imag = PW'(pr_i[ri][k]);
            end else begin
                prod_real = -17'sd12345;
                prod_imag = 17'sd4321;
            end
            if (tracking && cyc == dc + 1) begin
                if (m_hold && !chained) begin
                    chained   = 1;
                    ri        = 1;
                    cyc       = -1;
                    done_seen = -1;
                end else begin
                    if (lit_en) begin
                        check("lit_acc_real", acc_real, lit_r);
                        check("lit_acc_imag", acc_imag, lit_i);
                        check("lit_done_cycle", done_seen, lit_done);
                    end
                    tracking = 0;
                end
            end
        end
    end

    task automatic run(input int n, input bit hold, input bit pulses, input int rst_cyc,
                       input bit le, input longint lr, input longint li, input int ld);
        int c;
        @(negedge clk);
        #1;
        m_len    = n;
        m_hold   = hold;
        lit_en   = le;
        lit_r    = lr;
        lit_i    = li;
        lit_done = ld;
        len      = n[ADDR_W-1:0];
        start    = 1'b1;
        run_id++;
        @(posedge clk);
        #1;
        c = 0;
        if (!hold) start = 1'b0;
        while ((tracking || seen_id != run_id) && c < 100) begin
            @(posedge clk);
            #1;
            c++;
            if (hold && chained) start = 1'b0;
            if (pulses) start = (c == 2 || c == 5);
            if (c == rst_cyc) begin
                rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                #1 rst = 1'b1;
            end
        end
        start = 1'b0;
        if (c >= 100) begin
            $display("FAIL run_timeout: ran %0d cycles, limit %0d", c, 100);
            $fatal(1, "run did not complete");
        end
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        len    = '0;
        run_id = 0;
        m_len  = 0;
        m_hold = 0;
        lit_en = 0;
        lit_r  = 0;
        lit_i  = 0;
        lit_done = 0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 16; k++) begin
                pr_r[b][k] = 0;
                pr_i[b][k] = 0;
            end
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // basic len=4
        pr_r[0][0] = 1;  pr_i[0][0] = 2;
        pr_r[0][1] = 3;  pr_i[0][1] = -1;
        pr_r[0][2] = -5; pr_i[0][2] = 0;
        pr_r[0][3] = 2;  pr_i[0][3] = 2;
        run(4, 0, 0, -1, 1, 1, 3, 7);

        // len=0 clears accumulators, done at once
        run(0, 0, 0, -1, 1, 0, 0, 0);

        // start pulses mid-run are ignored
        run(4, 0, 1, -1, 1, 1, 3, 7);

        // reset in cycle 2, then a single-element run
        pr_r[0][0] = 10; pr_i[0][0] = 10;
        run(4, 0, 0, 2, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        pr_r[0][0] = 7; pr_i[0][0] = -7;
        run(1, 0, 0, -1, 1, 7, -7, 4);

        // start held: back-to-back len=2 runs
        pr_r[0][0] = 5;   pr_i[0][0] = -3;
        pr_r[0][1] = -2;  pr_i[0][1] = 4;
        pr_r[1][0] = 100; pr_i[1][0] = -100;
        pr_r[1][1] = 1;   pr_i[1][1] = 1;
        run(2, 1, 0, -1, 1, 101, -99, 5);

        // full length with extreme products
        for (int k = 0; k < 15; k++) begin
            pr_r[0][k] = -32768;
            pr_i[0][k] = 32767;
        end
        run(15, 0, 0, -1, 1, -491520, 491505, 18);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Control unit for the complex dot-product datapath. It sequences one RAM read per element pair into the complex multiplier, tracks the multiplier's fixed latency, and accumulates the complex products into real and imaginary sums. It sits between the top-level dot-product wrapper (`start`/`done`), the complex-number RAM, and the multiplier.

## Interface
- `WIDTH`, 8: bit width of each real or imaginary operand component.
- `ADDR_W`, 4: RAM address width; maximum vector length is 2^ADDR_W-1.
- `MULT_LAT`, 2: cycles from `mult_en` high to the corresponding `prod_*` being valid; must be ≥1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  start request; sampled only in IDLE.
- `len`  in  ADDR_W  number of element pairs; sampled with `start`.
- `ram_rd_en`  out  1  RAM read strobe; RAM data appears the next cycle.
- `ram_addr`  out  ADDR_W  RAM read address (element index).
- `mult_en`  out  1  multiplier input-valid; equals `ram_rd_en` delayed 1 cycle.
- `prod_real`, `prod_imag`  in  2*WIDTH+1 each, signed  multiplier outputs.
- `acc_real`, `acc_imag`  out  2*WIDTH+1+ADDR_W each, signed  accumulated sums; held until the next accepted start.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; results are valid while it is high.

## Operation
- FSM states are IDLE, ISSUE, DRAIN, DONE. All outputs are registered.
- IDLE, `start`=1, `len`≠0: clear both accumulators, latch `len`, issue counter=0, receive counter=0, go to ISSUE.
- IDLE, `start`=1, `len`=0: clear both accumulators, go to DONE. No RAM reads are issued.
- ISSUE: `ram_rd_en`=1 and `ram_addr`=issue count on every cycle.
  - The issue counter increments each cycle.
  - After `len` issues, go to DRAIN.
- Valid pipeline: `mult_en` feeds a MULT_LAT-deep shift register whose tail is `acc_en`.
- On each `acc_en` cycle:
  - sign-extend `prod_real`/`prod_imag` to the accumulator width and add them into `acc_real`/`acc_imag`;
  - increment the receive counter.
- `prod_*` are ignored on any cycle without `acc_en`.
- DRAIN: when the receive counter reaches `len`, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored in ISSUE, DRAIN and DONE. A held `start` is taken in the first IDLE cycle.
- Accumulator width 2W+1+ADDR_W cannot overflow for `len` < 2^ADDR_W; arithmetic is two's complement.
- Reset, asynchronous and at any time including mid-operation:
  - state goes to IDLE;
  - counters, pipeline, accumulators and all outputs go to 0;
  - the in-flight computation is discarded.

## Timing
- Cycle n is the period after rising edge n; edge 0 is the edge that samples `start`.
- Element k (0 ≤ k < len):
  - `ram_rd_en`/`ram_addr`=k in cycle k;
  - `mult_en` in cycle k+1;
  - `prod_*` valid in cycle k+1+MULT_LAT;
  - accumulated at edge k+2+MULT_LAT.
- `done` in cycle len+1+MULT_LAT, with final sums already visible. IDLE in the following cycle.
- `len`=0: `done` in cycle 0.
- Throughput is one element per cycle with no bubbles.

## Structure
- Package `dot_product_pkg` holds:
  - the state enum;
  - the accumulator-width function ACC_W(WIDTH,ADDR_W)=2*WIDTH+1+ADDR_W;
  - the product-width function PROD_W(WIDTH)=2*WIDTH+1.
- One sub-module, `valid_delay_line`: a parameterised 1-bit shift register (depth MULT_LAT, async active-low reset) that generates `acc_en` from `mult_en`.

## Test plan
- len=4, MULT_LAT=2, products (1,2),(3,-1),(-5,0),(2,2) returned in cycles 3..6 → `ram_addr` 0,1,2,3 in cycles 0..3; `mult_en` in cycles 1..4; `done` in cycle 7 only; `acc`=(1,3).
- len=0 → `done` in cycle 0; `acc`=(0,0); `ram_rd_en` never high; `busy` high for cycle 0 only.
- `start` pulsed in cycles 2 and 5 during a len=4 run → ignored; result and `done` timing identical to the first scenario.
- `rst` driven low in cycle 2 of a len=4 run → all outputs 0 immediately, state IDLE, no `done`; a subsequent len=1 run with product (7,-7) → `acc`=(7,-7).
- `start` held high continuously with len=2 → second run's `ram_rd_en` begins in the cycle after the post-`done` IDLE cycle; accumulators cleared between runs.
- len=15, WIDTH=8, every product (-32768,32767) → `acc`=(-491520,491505), no wrap; `done` in cycle 18.
